// File: rtl/alarm_clock_controller.sv
// Alarm clock time-of-day / alarm sequencer with a run / set-time / set-alarm mode FSM.
// Optional snooze support is built when ALARM_SNOOZE_EN is defined.
module alarm_clock_controller #(
    parameter int unsigned ALARM_TIMEOUT  = 10,
    parameter int unsigned SNOOZE_MINUTES = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_minute,
    input  logic       mode_btn,
    input  logic       hour_inc,
    input  logic       min_inc,
    input  logic       alarm_en,
    input  logic       alarm_off,
    input  logic       snooze,
    output logic [1:0] mode,
    output logic [4:0] time_hour,
    output logic [5:0] time_minute,
    output logic [4:0] alarm_hour,
    output logic [5:0] alarm_minute,
    output logic [4:0] disp_hour,
    output logic [5:0] disp_minute,
    output logic       sound_alarm
);

    localparam int unsigned HW = 5;
    localparam int unsigned MW = 6;
    localparam int unsigned TW = 6;

    localparam logic [1:0] MODE_RUN       = 2'd0;
    localparam logic [1:0] MODE_SET_TIME  = 2'd1;
    localparam logic [1:0] MODE_SET_ALARM = 2'd2;

    function automatic logic [HW-1:0] next_hour(input logic [HW-1:0] h);
        return (h == HW'(23)) ? '0 : h + HW'(1);
    endfunction

    function automatic logic [MW-1:0] next_min(input logic [MW-1:0] m);
        return (m == MW'(59)) ? '0 : m + MW'(1);
    endfunction

    logic [1:0]    mode_q,  mode_d;
    logic [HW-1:0] thour_q, thour_d;
    logic [MW-1:0] tmin_q,  tmin_d;
    logic [HW-1:0] ahour_q, ahour_d;
    logic [MW-1:0] amin_q,  amin_d;
    logic          sound_q, sound_d;
    logic [TW-1:0] tmo_q,   tmo_d;

    logic          edit_en;
    logic          tick_adv;
    logic [HW-1:0] adv_hour;
    logic [MW-1:0] adv_min;
    logic          trigger;
    logic          clear;
    logic          snz_trigger;
    logic          snz_hit;

`ifdef ALARM_SNOOZE_EN
    logic          pend_q,  pend_d;
    logic [HW-1:0] shour_q, shour_d;
    logic [MW-1:0] smin_q,  smin_d;
    logic [MW:0]   snz_sum;
`else
    logic          unused_snooze;
    assign unused_snooze = snooze;
`endif

    // Mode FSM plus time/alarm register editing and advancing.
    always_comb begin
        mode_d   = mode_q;
        thour_d  = thour_q;
        tmin_d   = tmin_q;
        ahour_d  = ahour_q;
        amin_d   = amin_q;
        edit_en  = !mode_btn;
        tick_adv = one_minute && (mode_q != MODE_SET_TIME);
        adv_min  = next_min(tmin_q);
        adv_hour = (tmin_q == MW'(59)) ? next_hour(thour_q) : thour_q;

        if (mode_btn) begin
            case (mode_q)
                MODE_RUN:      mode_d = MODE_SET_TIME;
                MODE_SET_TIME: mode_d = MODE_SET_ALARM;
                default:       mode_d = MODE_RUN;
            endcase
        end

        if (tick_adv) begin
            thour_d = adv_hour;
            tmin_d  = adv_min;
        end else if (mode_q == MODE_SET_TIME && edit_en) begin
            if (hour_inc) thour_d = next_hour(thour_q);
            if (min_inc)  tmin_d  = next_min(tmin_q);
        end

        if (mode_q == MODE_SET_ALARM && edit_en) begin
            if (hour_inc) ahour_d = next_hour(ahour_q);
            if (min_inc)  amin_d  = next_min(amin_q);
        end
    end

`ifdef ALARM_SNOOZE_EN
    // Snooze target is the current time plus the snooze delay, with 24h wrap.
    always_comb begin
        pend_d      = pend_q;
        shour_d     = shour_q;
        smin_d      = smin_q;
        snz_sum     = (MW+1)'(tmin_q) + (MW+1)'(SNOOZE_MINUTES);
        snz_hit     = snooze && sound_q;
        snz_trigger = pend_q && tick_adv && alarm_en && !sound_q &&
                      (adv_hour == shour_q) && (adv_min == smin_q);
        if (snz_hit) begin
            pend_d = 1'b1;
            if (snz_sum >= (MW+1)'(60)) begin
                smin_d  = MW'(snz_sum - (MW+1)'(60));
                shour_d = next_hour(thour_q);
            end else begin
                smin_d  = MW'(snz_sum);
                shour_d = thour_q;
            end
        end
        if (snz_trigger)            pend_d = 1'b0;
        if (alarm_off || !alarm_en) pend_d = 1'b0;
    end
`else
    assign snz_hit     = 1'b0;
    assign snz_trigger = 1'b0;
`endif

    // Alarm sounding and timeout; any clear source beats a same-cycle trigger.
    always_comb begin
        sound_d = sound_q;
        tmo_d   = tmo_q;
        trigger = tick_adv && alarm_en && !sound_q &&
                  (adv_hour == ahour_q) && (adv_min == amin_q);
        clear   = alarm_off || !alarm_en ||
                  (sound_q && one_minute && (tmo_q == TW'(ALARM_TIMEOUT - 1)));

        if (sound_q && one_minute) tmo_d = tmo_q + TW'(1);
        if (trigger || snz_trigger) begin
            sound_d = 1'b1;
            tmo_d   = '0;
        end
        if (clear || snz_hit) begin
            sound_d = 1'b0;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mode_q  <= MODE_RUN;
            thour_q <= '0;
            tmin_q  <= '0;
            ahour_q <= '0;
            amin_q  <= '0;
            sound_q <= 1'b0;
            tmo_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            thour_q <= thour_d;
            tmin_q  <= tmin_d;
            ahour_q <= ahour_d;
            amin_q  <= amin_d;
            sound_q <= sound_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            pend_q  <= 1'b0;
            shour_q <= '0;
            smin_q  <= '0;
        end else begin
            pend_q  <= pend_d;
            shour_q <= shour_d;
            smin_q  <= smin_d;
        end
    end
`endif

    assign mode         = mode_q;
    assign time_hour    = thour_q;
    assign time_minute  = tmin_q;
    assign alarm_hour   = ahour_q;
    assign alarm_minute = amin_q;
    assign sound_alarm  = sound_q;
    assign disp_hour    = (mode_q == MODE_SET_ALARM) ? ahour_q : thour_q;
    assign disp_minute  = (mode_q == MODE_SET_ALARM) ? amin_q  : tmin_q;

endmodule

// File: doc/alarm_clock_controller.md
Name: alarm_clock_controller

Overview:
- Time-of-day and alarm sequencer for the alarm clock.
- Consumes the 1-clock-per-minute tick from the timing generator and advances a 24-hour HH:MM time register.
- Runs a 3-state mode FSM (run / set time / set alarm) driven by debounced single-cycle button pulses, and asserts the alarm output on time match.
- Feeds the display mux and buzzer driver.

Parameters:
- ALARM_TIMEOUT, 10, minute ticks after which a sounding alarm self-clears (1..63).
- SNOOZE_MINUTES, 5, snooze delay in minutes; used only with ALARM_SNOOZE_EN (1..59).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous reset, active-low
- one_minute  in  1  1-cycle tick per minute from the timing generator
- mode_btn  in  1  1-cycle pulse; advances the mode FSM
- hour_inc  in  1  1-cycle pulse; increments hour of the register being set
- min_inc  in  1  1-cycle pulse; increments minute of the register being set
- alarm_en  in  1  level; alarm armed when 1
- alarm_off  in  1  1-cycle pulse; silences the alarm
- snooze  in  1  1-cycle pulse; snooze request (see Optional Feature)
- mode  out  2  0=RUN, 1=SET_TIME, 2=SET_ALARM
- time_hour  out  5  current hour, binary 0..23
- time_minute  out  6  current minute, binary 0..59
- alarm_hour  out  5  alarm hour 0..23
- alarm_minute  out  6  alarm minute 0..59
- disp_hour  out  5  alarm_hour in SET_ALARM, else time_hour (combinational mux of registers)
- disp_minute  out  6  alarm_minute in SET_ALARM, else time_minute
- sound_alarm  out  1  buzzer enable

Behaviour:
- Reset: all state updates on posedge clock. Reset is sampled only on posedge clock and is active while reset==0. Reset gives mode=RUN, time 00:00, alarm 00:00, sound_alarm=0, timeout counter 0, snooze state cleared.
- FSM: mode_btn steps RUN->SET_TIME->SET_ALARM->RUN. The transition is visible on mode the cycle after the pulse.
- Priority: mode_btn in the same cycle as hour_inc/min_inc means mode wins and the increments are dropped.
- RUN:
  - one_minute advances time by 1 minute, updating the cycle after the tick.
  - 59 min carries into the hour; 23:59 wraps to 00:00.
  - hour_inc and min_inc are ignored.
- SET_TIME:
  - one_minute is ignored; time is frozen.
  - min_inc: minute+1, 59->0 with no hour carry.
  - hour_inc: hour+1, 23->0.
  - Both pulses in the same cycle apply both increments.
- SET_ALARM:
  - Time keeps advancing on one_minute.
  - hour_inc and min_inc modify the alarm registers with the same wrap rules as SET_TIME.
- Alarm trigger:
  - Condition: a one_minute tick advances time (RUN or SET_ALARM) and the new time equals the alarm, with alarm_en==1.
  - sound_alarm rises 1 cycle after the tick.
  - Entering a matching time via SET_TIME edits never triggers.
- Alarm clear: sound_alarm falls the cycle after any of:
  - an alarm_off pulse;
  - alarm_en==0, sampled each cycle;
  - ALARM_TIMEOUT one_minute ticks counted while sounding.
- Timeout counter: cleared on trigger and on clear.
- Simultaneous trigger and alarm_off: clear wins, so sound_alarm stays 0.
- Trigger while already sounding: no effect; the timeout counter is not restarted.
- Mode changes do not affect sound_alarm.

Optional Feature:
- Macro: ALARM_SNOOZE_EN.
- Defined:
  - A snooze pulse while sound_alarm==1 clears sound_alarm next cycle.
  - It loads snooze_target = time + SNOOZE_MINUTES, with minute/hour carry and 24h wrap, and sets snooze_pending.
  - When a one_minute tick advances time to snooze_target with alarm_en==1 and snooze_pending, sound_alarm rises, snooze_pending clears, and the timeout restarts.
  - alarm_off, alarm_en==0, or reset clears snooze_pending.
  - A snooze pulse while not sounding is ignored.
- Undefined: the snooze port is present but ignored; no snooze registers exist.

Test Plan:
- Release reset, issue 60 one_minute ticks 256 cycles apart in RUN -> time 01:00; continue from 23:59 with 1 tick -> 00:00, mode=0.
- mode_btn x1, min_inc x61, hour_inc x25 plus 3 one_minute ticks -> mode=1, time 01:01, ticks ignored; mode_btn again -> mode=2, disp shows alarm 00:00.
- Set alarm 06:30, alarm_en=1, time 06:29, one tick -> sound_alarm=1 one cycle after tick; 10 more ticks -> sound_alarm=0 exactly after 10th tick.
- Sounding alarm, alarm_off pulse -> sound_alarm=0 next cycle; repeat with alarm_off coincident with trigger tick -> sound_alarm never rises.
- mode_btn and min_inc in same cycle while in SET_TIME -> mode=2, minute unchanged; assert reset low mid-SET_ALARM with sound_alarm=1 -> all outputs reset values next clock.
- With ALARM_SNOOZE_EN: alarm 07:00 sounds, snooze -> 0; after 5 ticks (07:05) -> sound_alarm=1; without the macro the snooze pulse leaves sound_alarm=1.
